// File: rtl/mantissa_add_normalizer.sv
// FP adder back end: effective add/subtract, normalize, round, pack; 3-stage valid/ready pipeline.
// Build option MANT_NORM_RNE_ROUND_EN selects round-to-nearest-even; otherwise the result is truncated.
module mantissa_add_normalizer #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic [MANTISSA_WIDTH+3:0]   mantissa_a_in,
    input  logic [MANTISSA_WIDTH+3:0]   mantissa_b_in,
    input  logic                        sign_a,
    input  logic                        sign_b,
    input  logic [EXP_WIDTH-1:0]        exp_in,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic                        sign_out,
    output logic [EXP_WIDTH-1:0]        exp_out,
    output logic [MANTISSA_WIDTH-1:0]   mant_out,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int W  = MANTISSA_WIDTH + 4;
    localparam int SW = $clog2(W);
    localparam int XW = EXP_WIDTH + 2;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_WIDTH) - 1);

    // Left-shift distance that brings the leading one to the hidden-bit position
    function automatic logic [SW-1:0] lead_shift(input logic [W-1:0] v);
        logic [SW-1:0] sh;
        sh = {SW{1'b0}};
        for (int i = 0; i < W; i++) begin
            if (v[i]) begin
                sh = SW'(W - 1 - i);
            end
        end
        return sh;
    endfunction

    logic stall_s;
    logic accept_s;
    logic rdy_en_r;

    assign stall_s  = valid_out & ~ready_out;
    assign ready_in = rdy_en_r & ~stall_s;
    assign accept_s = valid_in & ready_in;

    // Input ready comes up on the first clock after reset release
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
        end
    end

    logic         eff_sub_s;
    logic         a_ge_b_s;
    logic [W:0]   sum_s;
    logic         sign1_s;

    // Stage 1 combinational: magnitude add or subtract, larger-magnitude sign wins
    always_comb begin
        eff_sub_s = sign_a ^ sign_b;
        a_ge_b_s  = (mantissa_a_in >= mantissa_b_in);
        if (!eff_sub_s) begin
            sum_s   = {1'b0, mantissa_a_in} + {1'b0, mantissa_b_in};
            sign1_s = sign_a;
        end else if (a_ge_b_s) begin
            sum_s   = {1'b0, mantissa_a_in} - {1'b0, mantissa_b_in};
            sign1_s = sign_a;
        end else begin
            sum_s   = {1'b0, mantissa_b_in} - {1'b0, mantissa_a_in};
            sign1_s = sign_b;
        end
    end

    logic                 s1_valid_r;
    logic [W:0]           s1_sum_r;
    logic                 s1_sign_r;
    logic [EXP_WIDTH-1:0] s1_exp_r;

    // Stage 1 register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= {(W+1){1'b0}};
            s1_sign_r  <= 1'b0;
            s1_exp_r   <= {EXP_WIDTH{1'b0}};
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            s1_sum_r   <= sum_s;
            s1_sign_r  <= sign1_s;
            s1_exp_r   <= exp_in;
        end
    end

    logic [SW-1:0] sh_s;
    logic [W-1:0]  norm_s;
    logic [XW-1:0] nexp_s;
    logic          zero2_s;
    logic          uf2_s;

    // Stage 2 combinational: normalize; exponent is two's complement so a non-positive result is visible
    always_comb begin
        sh_s    = lead_shift(s1_sum_r[W-1:0]);
        zero2_s = (s1_sum_r == {(W+1){1'b0}});
        if (s1_sum_r[W]) begin
            norm_s = {s1_sum_r[W:2], s1_sum_r[1] | s1_sum_r[0]};
            nexp_s = XW'(s1_exp_r) + XW'(1);
        end else begin
            norm_s = s1_sum_r[W-1:0] << sh_s;
            nexp_s = XW'(s1_exp_r) - XW'(sh_s);
        end
        uf2_s = ~zero2_s & (nexp_s[XW-1] | (nexp_s == {XW{1'b0}}));
    end

    logic          s2_valid_r;
    logic [W-1:0]  s2_norm_r;
    logic [XW-1:0] s2_exp_r;
    logic          s2_sign_r;
    logic          s2_uf_r;

    // Stage 2 register; zero and underflow results carry a cleared mantissa
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s2_valid_r <= 1'b0;
            s2_norm_r  <= {W{1'b0}};
            s2_exp_r   <= {XW{1'b0}};
            s2_sign_r  <= 1'b0;
            s2_uf_r    <= 1'b0;
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            s2_norm_r  <= (zero2_s | uf2_s) ? {W{1'b0}} : norm_s;
            s2_exp_r   <= nexp_s;
            s2_sign_r  <= zero2_s ? 1'b0 : s1_sign_r;
            s2_uf_r    <= uf2_s;
        end
    end

    logic [XW-1:0]             rexp_s;
    logic [MANTISSA_WIDTH-1:0] rfrac_s;
    logic                      zero3_s;
    logic                      sign_nx_s;
    logic [EXP_WIDTH-1:0]      exp_nx_s;
    logic [MANTISSA_WIDTH-1:0] mant_nx_s;
    logic                      ovf_nx_s;
    logic                      uf_nx_s;

`ifdef MANT_NORM_RNE_ROUND_EN
    logic                      rnd_inc_s;
    logic [MANTISSA_WIDTH:0]   rnd_sum_s;

    // Stage 3 rounding: RNE; hidden bit is 1 here, so a fraction carry is the hidden-bit carry
    always_comb begin
        rnd_inc_s = s2_norm_r[2] & (s2_norm_r[1] | s2_norm_r[0] | s2_norm_r[3]);
        rnd_sum_s = {1'b0, s2_norm_r[W-2:3]} + (MANTISSA_WIDTH+1)'(rnd_inc_s);
        rfrac_s   = rnd_sum_s[MANTISSA_WIDTH-1:0];
        rexp_s    = s2_exp_r + XW'(rnd_sum_s[MANTISSA_WIDTH]);
    end
`else
    logic grs_unused_s;
    assign grs_unused_s = ^s2_norm_r[2:0];

    // Stage 3 rounding: truncate guard/round/sticky
    always_comb begin
        rfrac_s = s2_norm_r[W-2:3];
        rexp_s  = s2_exp_r;
    end
`endif

    // Stage 3 packing: zero, underflow, overflow-to-infinity or normal result
    always_comb begin
        zero3_s   = ~s2_norm_r[W-1] & ~s2_uf_r;
        sign_nx_s = s2_sign_r;
        exp_nx_s  = {EXP_WIDTH{1'b0}};
        mant_nx_s = {MANTISSA_WIDTH{1'b0}};
        ovf_nx_s  = 1'b0;
        uf_nx_s   = 1'b0;
        if (zero3_s) begin
            sign_nx_s = 1'b0;
        end else if (s2_uf_r) begin
            uf_nx_s = 1'b1;
        end else if (rexp_s >= EXP_MAX) begin
            exp_nx_s = {EXP_WIDTH{1'b1}};
            ovf_nx_s = 1'b1;
        end else begin
            exp_nx_s  = rexp_s[EXP_WIDTH-1:0];
            mant_nx_s = rfrac_s;
        end
    end

    // Stage 3 / output register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_out <= 1'b0;
            sign_out  <= 1'b0;
            exp_out   <= {EXP_WIDTH{1'b0}};
            mant_out  <= {MANTISSA_WIDTH{1'b0}};
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!stall_s) begin
            valid_out <= s2_valid_r;
            sign_out  <= sign_nx_s;
            exp_out   <= exp_nx_s;
            mant_out  <= mant_nx_s;
            overflow  <= ovf_nx_s;
            underflow <= uf_nx_s;
        end
    end

endmodule
